// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-lane gate arbiter.
package arbitro_pkg;

    typedef enum logic [1:0] {
        LIBRE     = 2'd0,
        CONCEDIDO = 2'd1,
        BLOQUEADO = 2'd2
    } estado_e;

    localparam logic CARRIL_0 = 1'b0;
    localparam logic CARRIL_1 = 1'b1;

    // One-hot grant vector for a lane index.
    function automatic logic [1:0] a_onehot(input logic carril);
        return (carril == CARRIL_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arbitro_carriles_temporizador.sv
// Grant timer: counts cycles of an active grant, saturating at the timeout value.
module temporizador_concesion
    import arbitro_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic limpiar,
    input  logic congelar,
    output logic vencido
);

    localparam int ANCHO = $clog2(TIMEOUT_CICLOS);
    localparam logic [ANCHO-1:0] LIMITE = ANCHO'(TIMEOUT_CICLOS - 1);

    logic [ANCHO-1:0] cuenta_q;
    logic [ANCHO-1:0] cuenta_d;

    // Next count: clear wins, then advance unless frozen or already at the limit.
    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar) begin
            cuenta_d = '0;
        end else if (!congelar && (cuenta_q != LIMITE)) begin
            cuenta_d = cuenta_q + ANCHO'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign vencido = (cuenta_q == LIMITE);

endmodule

// File: rtl/arbitro_carriles.sv
// Two-lane round-robin arbiter sharing one parking-gate controller.
//
// state     | meaning
// LIBRE     | no lane granted, controller inputs forced low
// CONCEDIDO | one lane routed to the controller, grant timer running
// BLOQUEADO | controller in lockout, grant held until the alarm clears
module arbitro_carriles
    import arbitro_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] solicitud,
    input  logic [1:0] paso,
    input  logic       pin_validation_c0,
    input  logic       pin_validation_c1,
    input  logic [7:0] pin_c0,
    input  logic [7:0] pin_c1,
    output logic       sensor_a,
    output logic       sensor_b,
    output logic       pin_validation,
    output logic [7:0] pin,
    input  logic       alarma_bloqueo,
    input  logic       senal_abrir_compuerta,
    input  logic       senal_cerrar_compuerta,
    output logic [1:0] concesion,
    output logic       ocupado,
    output logic       expiro
);

    estado_e    estado_q, estado_d;
    logic [1:0] concesion_q, concesion_d;
    logic       ultimo_q, ultimo_d;
    logic       expiro_q, expiro_d;
    logic       abierto_q, abierto_d;
    logic       carril_nuevo;
    logic       carril_act;
    logic       vencido;
    logic       limpiar;
    logic       congelar;

    assign carril_act = concesion_q[1] ? CARRIL_1 : CARRIL_0;

    // The timer only runs while granted and before the gate has ever opened.
    assign limpiar  = (estado_q == LIBRE);
    assign congelar = (estado_q != CONCEDIDO) || abierto_q || senal_abrir_compuerta;

    temporizador_concesion #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .limpiar (limpiar),
        .congelar(congelar),
        .vencido (vencido)
    );

    // Next-state logic: grant selection, exit priority and round-robin update.
    always_comb begin
        estado_d     = estado_q;
        concesion_d  = concesion_q;
        ultimo_d     = ultimo_q;
        expiro_d     = 1'b0;
        abierto_d    = abierto_q;
        carril_nuevo = solicitud[1] ? CARRIL_1 : CARRIL_0;
        if (solicitud == 2'b11) begin
            carril_nuevo = ~ultimo_q;
        end
        case (estado_q)
            LIBRE: begin
                abierto_d = 1'b0;
                if (solicitud != 2'b00) begin
                    concesion_d = a_onehot(carril_nuevo);
                    estado_d    = CONCEDIDO;
                end
            end
            CONCEDIDO: begin
                if (senal_abrir_compuerta) begin
                    abierto_d = 1'b1;
                end
                if (alarma_bloqueo) begin
                    estado_d = BLOQUEADO;
                end else if (senal_cerrar_compuerta) begin
                    estado_d    = LIBRE;
                    concesion_d = 2'b00;
                    ultimo_d    = carril_act;
                end else if (vencido && !abierto_q && !senal_abrir_compuerta) begin
                    estado_d    = LIBRE;
                    concesion_d = 2'b00;
                    ultimo_d    = carril_act;
                    expiro_d    = 1'b1;
                end
            end
            BLOQUEADO: begin
                if (!alarma_bloqueo) begin
                    estado_d    = LIBRE;
                    concesion_d = 2'b00;
                    ultimo_d    = carril_act;
                end
            end
            default: begin
                estado_d    = LIBRE;
                concesion_d = 2'b00;
            end
        endcase
    end

    // State and grant registers; lane 0 wins the first tie after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= LIBRE;
            concesion_q <= 2'b00;
            ultimo_q    <= CARRIL_1;
            expiro_q    <= 1'b0;
            abierto_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            concesion_q <= concesion_d;
            ultimo_q    <= ultimo_d;
            expiro_q    <= expiro_d;
            abierto_q   <= abierto_d;
        end
    end

    // Route the granted lane to the controller; everything low when idle.
    always_comb begin
        sensor_a       = 1'b0;
        sensor_b       = 1'b0;
        pin_validation = 1'b0;
        pin            = 8'h00;
        case (concesion_q)
            2'b01: begin
                sensor_a       = solicitud[0];
                sensor_b       = paso[0];
                pin_validation = pin_validation_c0;
                pin            = pin_c0;
            end
            2'b10: begin
                sensor_a       = solicitud[1];
                sensor_b       = paso[1];
                pin_validation = pin_validation_c1;
                pin            = pin_c1;
            end
            default: begin
                sensor_a       = 1'b0;
                sensor_b       = 1'b0;
                pin_validation = 1'b0;
                pin            = 8'h00;
            end
        endcase
    end

    assign concesion = concesion_q;
    assign ocupado   = |concesion_q;
    assign expiro    = expiro_q;

endmodule

// File: tb/tb_arbitro_carriles.sv
// Scoreboard bench for arbitro_carriles: directed scenarios followed by random traffic.
module tb_arbitro_carriles;

    localparam int T = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] solicitud;
    logic [1:0] paso;
    logic       pin_validation_c0;
    logic       pin_validation_c1;
    logic [7:0] pin_c0;
    logic [7:0] pin_c1;
    logic       sensor_a;
    logic       sensor_b;
    logic       pin_validation;
    logic [7:0] pin;
    logic       alarma_bloqueo;
    logic       senal_abrir_compuerta;
    logic       senal_cerrar_compuerta;
    logic [1:0] concesion;
    logic       ocupado;
    logic       expiro;

    int checks   = 0;
    int failures = 0;

    int exp_lane_q[$];
    bit exp_exp_q[$];

    // Reference model state: which lane holds the controller (-1 = nobody).
    int m_lane;
    int m_last;
    int m_grant_cycle;
    int m_cycle = 0;
    bit m_locked;
    bit m_opened;

    arbitro_carriles #(.TIMEOUT_CICLOS(T)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .solicitud             (solicitud),
        .paso                  (paso),
        .pin_validation_c0     (pin_validation_c0),
        .pin_validation_c1     (pin_validation_c1),
        .pin_c0                (pin_c0),
        .pin_c1                (pin_c1),
        .sensor_a              (sensor_a),
        .sensor_b              (sensor_b),
        .pin_validation        (pin_validation),
        .pin                   (pin),
        .alarma_bloqueo        (alarma_bloqueo),
        .senal_abrir_compuerta (senal_abrir_compuerta),
        .senal_cerrar_compuerta(senal_cerrar_compuerta),
        .concesion             (concesion),
        .ocupado               (ocupado),
        .expiro                (expiro)
    );

    always #5 clock = ~clock;

    // Model: at every edge decide who owns the controller afterwards, push the expectation.
    always @(posedge clock) begin : modelo
        bit e;
        m_cycle = m_cycle + 1;
        e = 1'b0;
        if (reset) begin
            m_lane   = -1;
            m_last   = 1;
            m_locked = 1'b0;
            m_opened = 1'b0;
        end else if (m_lane < 0) begin
            if (solicitud == 2'b11)  m_lane = 1 - m_last;
            else if (solicitud[0])   m_lane = 0;
            else if (solicitud[1])   m_lane = 1;
            if (m_lane >= 0) begin
                m_grant_cycle = m_cycle;
                m_opened      = 1'b0;
                m_locked      = 1'b0;
            end
        end else if (m_locked) begin
            if (!alarma_bloqueo) begin
                m_last = m_lane;
                m_lane = -1;
            end
        end else begin
            if (senal_abrir_compuerta) m_opened = 1'b1;
            if (alarma_bloqueo) begin
                m_locked = 1'b1;
            end else if (senal_cerrar_compuerta) begin
                m_last = m_lane;
                m_lane = -1;
            end else if (!m_opened && (m_cycle - m_grant_cycle == T)) begin
                e      = 1'b1;
                m_last = m_lane;
                m_lane = -1;
            end
        end
        exp_lane_q.push_back(m_lane);
        exp_exp_q.push_back(e);
    end

    // Monitor: pop one expectation per cycle and compare grant, flags and routed signals.
    always @(negedge clock) begin : monitor
        int         l;
        bit         e;
        logic [1:0] ec;
        logic [10:0] em;
        logic [10:0] am;
        if (exp_lane_q.size() > 0) begin
            l  = exp_lane_q.pop_front();
            e  = exp_exp_q.pop_front();
            ec = (l < 0) ? 2'b00 : ((l == 0) ? 2'b01 : 2'b10);
            checks = checks + 1;
            if (concesion !== ec || ocupado !== (l >= 0) || expiro !== e) begin
                failures = failures + 1;
                $display("FAIL grant t=%0t concesion=%b ocupado=%b expiro=%b expected concesion=%b ocupado=%b expiro=%b",
                         $time, concesion, ocupado, expiro, ec, (l >= 0), e);
            end
            if (l == 0)      em = {solicitud[0], paso[0], pin_validation_c0, pin_c0};
            else if (l == 1) em = {solicitud[1], paso[1], pin_validation_c1, pin_c1};
            else             em = 11'd0;
            am = {sensor_a, sensor_b, pin_validation, pin};
            checks = checks + 1;
            if (am !== em) begin
                failures = failures + 1;
                $display("FAIL mux t=%0t actual=%h expected=%h", $time, am, em);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    initial begin
        reset = 1'b1;
        solicitud = 2'b00;
        paso = 2'b00;
        pin_validation_c0 = 1'b0;
        pin_validation_c1 = 1'b0;
        pin_c0 = 8'h00;
        pin_c1 = 8'h00;
        alarma_bloqueo = 1'b0;
        senal_abrir_compuerta = 1'b0;
        senal_cerrar_compuerta = 1'b0;
        tick();
        tick();
        chk("reset_concesion", concesion, 8'h00);
        chk("reset_expiro", expiro, 8'h00);
        reset = 1'b0;

        // Lane 0 alone, PIN routed, normal release.
        solicitud = 2'b01;
        tick();
        chk("grant_l0", concesion, 8'h01);
        solicitud = 2'b00;
        pin_c0 = 8'hA5;
        pin_c1 = 8'h3C;
        pin_validation_c0 = 1'b1;
        #1;
        chk("pin_l0", pin, 8'hA5);
        chk("pinval_l0", pin_validation, 8'h01);
        tick();
        pin_validation_c0 = 1'b0;
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        chk("release_l0", concesion, 8'h00);

        // Tie after reset goes to lane 0, then lane 1 after one idle cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        solicitud = 2'b11;
        tick();
        chk("tie_first", concesion, 8'h01);
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        chk("tie_gap", concesion, 8'h00);
        tick();
        chk("tie_second", concesion, 8'h02);
        solicitud = 2'b00;
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        chk("tie_release", concesion, 8'h00);

        // Timeout on lane 1: revoked exactly T edges after the grant.
        solicitud = 2'b10;
        tick();
        chk("to_grant", concesion, 8'h02);
        solicitud = 2'b00;
        repeat (T - 1) tick();
        chk("to_hold", concesion, 8'h02);
        chk("to_noexp", expiro, 8'h00);
        tick();
        chk("to_release", concesion, 8'h00);
        chk("to_expiro", expiro, 8'h01);
        tick();
        chk("to_pulse_end", expiro, 8'h00);
        solicitud = 2'b11;
        tick();
        chk("to_next_tie", concesion, 8'h01);
        solicitud = 2'b00;
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        tick();

        // Gate opened early freezes the timer; long grant ends only on close.
        solicitud = 2'b01;
        tick();
        solicitud = 2'b00;
        repeat (5) tick();
        senal_abrir_compuerta = 1'b1;
        tick();
        senal_abrir_compuerta = 1'b0;
        repeat (34) tick();
        chk("open_hold", concesion, 8'h01);
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        chk("open_release", concesion, 8'h00);
        chk("open_noexp", expiro, 8'h00);

        // Reset mid-grant restores the tie pointer.
        solicitud = 2'b01;
        tick();
        chk("rst_grant", concesion, 8'h01);
        solicitud = 2'b00;
        paso = 2'b11;
        pin_c0 = 8'hFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_concesion", concesion, 8'h00);
        #1;
        chk("rst_sensor_b", sensor_b, 8'h00);
        chk("rst_pin", pin, 8'h00);
        paso = 2'b00;
        solicitud = 2'b11;
        tick();
        chk("rst_tie", concesion, 8'h01);
        solicitud = 2'b00;
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        tick();

        // Lockout beats close; grant held until the alarm drops.
        solicitud = 2'b10;
        tick();
        chk("lock_grant", concesion, 8'h02);
        solicitud = 2'b00;
        alarma_bloqueo = 1'b1;
        senal_cerrar_compuerta = 1'b1;
        tick();
        senal_cerrar_compuerta = 1'b0;
        chk("lock_held", concesion, 8'h02);
        repeat (3) tick();
        chk("lock_still", concesion, 8'h02);
        alarma_bloqueo = 1'b0;
        tick();
        chk("lock_release", concesion, 8'h00);

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            solicitud              = 2'($urandom_range(0, 3));
            paso                   = 2'($urandom_range(0, 3));
            pin_validation_c0      = 1'($urandom_range(0, 1));
            pin_validation_c1      = 1'($urandom_range(0, 1));
            pin_c0                 = 8'($urandom);
            pin_c1                 = 8'($urandom);
            senal_abrir_compuerta  = ($urandom_range(0, 19) == 0);
            senal_cerrar_compuerta = ($urandom_range(0, 24) == 0);
            if (alarma_bloqueo) alarma_bloqueo = ($urandom_range(0, 4) != 0);
            else                alarma_bloqueo = ($urandom_range(0, 59) == 0);
            reset                  = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbitro_carriles.md
# arbitro_carriles

Two-lane access arbiter in front of the single parking-gate `controlador`. Two entry lanes, each with its own sensors and PIN keypad, share one `controlador` instance. The block grants the controller to one lane at a time using round-robin order and routes that lane's sensors and PIN to it. It holds the grant until the vehicle has passed, the PIN attempt times out, or a lockout clears.

## Interface
Parameters:
- `TIMEOUT_CICLOS`, default 16: cycles a granted lane has to get the gate opened before the grant is revoked. Must be ≥ 2.

Ports:
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `solicitud`  in  2  per-lane `sensor_a` (vehicle waiting); bit 0 = lane 0.
- `paso`  in  2  per-lane `sensor_b` (vehicle passing).
- `pin_validation_c0`, `pin_validation_c1`  in  1  per-lane PIN strobe.
- `pin_c0`, `pin_c1`  in  8  per-lane PIN value.
- `sensor_a`, `sensor_b`, `pin_validation`  out  1  to `controlador`, muxed from the granted lane.
- `pin`  out  8  to `controlador`, muxed from the granted lane.
- `alarma_bloqueo`, `senal_abrir_compuerta`, `senal_cerrar_compuerta`  in  1  from `controlador`.
- `concesion`  out  2  one-hot grant, or 0 when idle.
- `ocupado`  out  1  high whenever `concesion` != 0.
- `expiro`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Reset values:
  - state LIBRE
  - `concesion`=0, `ocupado`=0, `expiro`=0
  - all controller-side outputs 0
  - round-robin pointer `ultimo`=1, so lane 0 wins the first tie
  - timer 0
- LIBRE:
  - If exactly one `solicitud` bit is set, grant that lane.
  - If both are set, grant the lane ≠ `ultimo`.
  - A grant loads `concesion` and clears the timer; next state is CONCEDIDO.
- CONCEDIDO:
  - Controller outputs equal the granted lane's inputs. The other lane's inputs are ignored.
  - The timer increments each cycle until the first cycle `senal_abrir_compuerta`=1 is seen. From then on the timer freezes and cannot expire.
  - Exit priority, highest first:
    1. `alarma_bloqueo`=1 → BLOQUEADO.
    2. `senal_cerrar_compuerta`=1 → LIBRE, normal release.
    3. Timer == `TIMEOUT_CICLOS`-1 with the gate never opened → LIBRE, pulse `expiro`.
  - Every exit to LIBRE clears `concesion` and sets `ultimo` to the released lane.
- BLOQUEADO:
  - The grant is held and the mux stays active, so the controller still sees the lane.
  - The timer is frozen.
  - When `alarma_bloqueo` returns to 0 → LIBRE; `ultimo` is set to the locked lane.
- With `concesion`=0, all controller-side outputs are forced to 0.
- Timer width is $clog2(`TIMEOUT_CICLOS`). No wrap is possible, because the timer is cleared on every grant.

## Timing
- Grant latency: `solicitud` sampled high in LIBRE → `concesion` valid on the next edge. Controller inputs follow combinationally from registered `concesion` in that same cycle.
- Release latency: `senal_cerrar_compuerta` sampled high → `concesion`=0 on the next edge.
- At least one LIBRE cycle always separates two grants, so the controller always sees `sensor_a` drop between vehicles.
- Timeout: if the grant is issued at edge N and the gate never opens, `expiro`=1 and `concesion`=0 take effect at edge N+`TIMEOUT_CICLOS`.
- Simultaneous `alarma_bloqueo` and `senal_cerrar_compuerta` resolves to BLOQUEADO.
- A request withdrawn while granted does not release the grant. Only the exits listed under CONCEDIDO do.
- Reset asserted mid-grant: the next edge returns every reset value listed above. Any in-flight PIN attempt is discarded.

## Structure
- Shared package `arbitro_pkg`:
  - state encoding: LIBRE=2'd0, CONCEDIDO=2'd1, BLOQUEADO=2'd2
  - lane constants `CARRIL_0`, `CARRIL_1`
- Sub-module `temporizador_concesion` holds the grant timer:
  - inputs: `clock`, `reset`, `limpiar`, `congelar`
  - output: `vencido`
  - parameter: `TIMEOUT_CICLOS`
- The FSM, round-robin pointer and output mux stay in the top module.

## Test plan
- Lane 0 only:
  - `solicitud`=01 → `concesion`=01 one cycle later.
  - Drive `pin_c0`=8'hA5 and strobe `pin_validation_c0` → controller sees `pin`=A5.
  - Assert `senal_cerrar_compuerta` → `concesion`=00 next cycle.
- Tie:
  - After reset, `solicitud`=11 → lane 0 granted.
  - After its release with `solicitud` still 11 → lane 1 granted after exactly one LIBRE cycle.
- Timeout, with `TIMEOUT_CICLOS`=16:
  - Lane 1 granted at edge N, no `senal_abrir_compuerta` → `expiro`=1 and `concesion`=00 at edge N+16.
  - The next tie goes to lane 0.
- Gate opened at cycle 5 of a grant, `senal_cerrar_compuerta` at cycle 40 → no `expiro`; release on cycle 41.
- Lockout:
  - `alarma_bloqueo`=1 together with `senal_cerrar_compuerta`=1 → grant held (BLOQUEADO).
  - `alarma_bloqueo` drops → `concesion`=00 next cycle.
- `reset`=1 mid-grant with lane 0 granted → next edge has `concesion`=00, all controller outputs 0, and lane 0 wins the next tie.
